// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder end of the LSU data-memory interface. A single-ported word array
// serves reads from a small FIFO of pending requests. Each request must wait at
// least RD_LAT cycles before its response. Writes own the port whenever they
// are presented, so a write delays the read at the head of the FIFO. Reads
// still complete strictly in order. The protocol has no ready signal. A read
// that arrives while the FIFO is full is dropped, and the sticky rd_ovf flag
// records the drop.
//
// Parameters
//   XLEN       data / address width in bits
//   MEM_WORDS  array depth in XLEN-bit words (power of two)
//   RD_LAT     minimum request->response latency in cycles (>= 2)
//   RQ_DEPTH   pending-read FIFO depth (power of two, >= 2)
//   INIT_FILE  preload name (array is loaded through the write port instead)
//
// Ports
//   clk       in   clock, all state on posedge
//   rst       in   asynchronous active-high reset
//   rd_valid  in   read request
//   rd_addr   in   byte address of the read
//   rd_resp   out  one-cycle pulse: rd_data holds the oldest outstanding read
//   rd_data   out  registered read data
//   wr_valid  in   write request, applied at this clock edge
//   wr_addr   in   byte address of the write
//   wr_data   in   write data, full word
//   rq_full   out  FIFO holds RQ_DEPTH entries
//   rd_ovf    out  sticky: a read was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int    XLEN      = 32,
    parameter int    MEM_WORDS = 1024,
    parameter int    RD_LAT    = 2,
    parameter int    RQ_DEPTH  = 4,
    parameter string INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_valid,
    input  logic [XLEN-1:0] rd_addr,
    output logic            rd_resp,
    output logic [XLEN-1:0] rd_data,
    input  logic            wr_valid,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            rq_full,
    output logic            rd_ovf
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(RQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // An entry's age saturates at RD_LAT-2. The width is kept at least
    // one bit so that the RD_LAT == 2 case still has a legal vector.
    localparam int AGE_W = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(RD_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RQ_DEPTH);

    // Word array (not reset)
    logic [XLEN-1:0] mem [MEM_WORDS];

    // FIFO storage: word index (payload, not reset) and age (reset)
    logic [IDX_W-1:0] rq_idx_q [RQ_DEPTH];
    logic [IDX_W-1:0] rq_idx_d [RQ_DEPTH];
    logic [AGE_W-1:0] rq_age_q [RQ_DEPTH];
    logic [AGE_W-1:0] rq_age_d [RQ_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             rd_resp_q, rd_resp_d;
    logic [XLEN-1:0]  rd_data_q, rd_data_d;
    logic             rd_ovf_q,  rd_ovf_d;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             full;
    logic             head_ready;
    logic             push;
    logic             pop;
    logic             drop;

    // Upper address bits wrap modulo MEM_WORDS, and the byte-lane bits are
    // ignored, so these bits are intentionally discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr[XLEN-1:IDX_W+2], rd_addr[1:0],
                                wr_addr[XLEN-1:IDX_W+2], wr_addr[1:0]};

    assign rd_idx = rd_addr[IDX_W+1:2];
    assign wr_idx = wr_addr[IDX_W+1:2];

    // ---- request stage: enqueue, age, arbitrate ------------------------------
    always_comb begin
        full       = (count_q == CNT_FULL);
        head_ready = (count_q != '0) && (rq_age_q[rd_ptr_q] == AGE_MAX);
        // Fullness is judged before this cycle's pop. A pop therefore never
        // frees a slot for a push in the same cycle.
        push       = rd_valid && !full;
        drop       = rd_valid && full;
        // A write owns the port, so no read can collide with it.
        pop        = head_ready && !wr_valid;

        for (int i = 0; i < RQ_DEPTH; i++) begin
            rq_idx_d[i] = rq_idx_q[i];
            rq_age_d[i] = rq_age_q[i];
            if (rq_age_q[i] != AGE_MAX) begin
                rq_age_d[i] = rq_age_q[i] + AGE_W'(1);
            end
        end
        if (push) begin
            rq_idx_d[wr_ptr_q] = rd_idx;
            rq_age_d[wr_ptr_q] = '0;
        end

        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

        rd_resp_d = pop;
        rd_data_d = pop ? mem[rq_idx_q[rd_ptr_q]] : rd_data_q;
        rd_ovf_d  = rd_ovf_q | drop;
    end

    // ---- response stage: registered state -------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_resp_q <= 1'b0;
            rd_data_q <= '0;
            rd_ovf_q  <= 1'b0;
            for (int i = 0; i < RQ_DEPTH; i++) begin
                rq_age_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_resp_q <= rd_resp_d;
            rd_data_q <= rd_data_d;
            rd_ovf_q  <= rd_ovf_d;
            for (int i = 0; i < RQ_DEPTH; i++) begin
                rq_age_q[i] <= rq_age_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < RQ_DEPTH; i++) begin
            rq_idx_q[i] <= rq_idx_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_valid) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_resp = rd_resp_q;
    assign rd_data = rd_data_q;
    assign rq_full = full;
    assign rd_ovf  = rd_ovf_q;

endmodule
